// File: rtl/bram_linebuf_ctrl.sv
// Rotating NBANK-line buffer sequencer: writes each incoming line into one subbank
// and, once NBANK-1 lines are stored, emits vertically aligned pixel columns.
module bram_linebuf_ctrl #(
    parameter int NBANK      = 4,
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [NBANK*DATA_WIDTH-1:0] m_data,
    output logic                        m_last,
    output logic [NBANK-1:0]            bank_cs,
    output logic [NBANK-1:0]            bank_re,
    output logic [NBANK-1:0]            bank_we,
    output logic [ADDR_WIDTH-1:0]       bank_raddr,
    output logic [ADDR_WIDTH-1:0]       bank_waddr,
    output logic [DATA_WIDTH-1:0]       bank_din,
    input  logic [NBANK*DATA_WIDTH-1:0] bank_dout
);
    localparam int          WB = $clog2(NBANK);
    localparam int unsigned NB = NBANK;

    typedef enum logic {FILL, STREAM} state_t;

    state_t                r_state;
    logic [WB-1:0]         r_wbank;
    logic [ADDR_WIDTH-1:0] r_wcol;
    logic [WB-1:0]         r_lines;
    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_newest;
    logic [WB-1:0]         r_rd_base;

    logic                  w_fire;
    logic                  w_stream;
    logic                  w_wrap;
    logic [WB-1:0]         w_wbank_nxt;
    logic [NBANK-1:0]      w_we;
    logic [NBANK-1:0]      w_re;

    assign s_ready     = !r_valid | m_ready;
    assign w_fire      = s_valid & s_ready;
    assign w_stream    = (r_state == STREAM);
    assign w_wrap      = (r_wcol == ADDR_WIDTH'(DEPTH - 1));
    assign w_wbank_nxt = (r_wbank == WB'(NBANK - 1)) ? '0 : r_wbank + 1'b1;

    always_comb begin
        w_we = '0;
        w_re = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_we[i] = w_fire & (WB'(i) == r_wbank);
            w_re[i] = w_fire & w_stream & (WB'(i) != r_wbank);
        end
    end

    assign bank_we    = w_we;
    assign bank_re    = w_re;
    assign bank_cs    = w_we | w_re;
    assign bank_raddr = r_wcol;
    assign bank_waddr = r_wcol;
    assign bank_din   = s_data;

    // Oldest stored line sits in the bank just after the one being written.
    always_comb begin
        int unsigned idx;
        m_data = '0;
        for (int unsigned k = 0; k < NB - 1; k++) begin
            idx = (32'(r_rd_base) + k) % NB;
            m_data[k*DATA_WIDTH +: DATA_WIDTH] = bank_dout[idx*DATA_WIDTH +: DATA_WIDTH];
        end
        m_data[(NB-1)*DATA_WIDTH +: DATA_WIDTH] = r_newest;
    end

    assign m_valid = r_valid;
    assign m_last  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_wbank   <= '0;
            r_wcol    <= '0;
            r_lines   <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_newest  <= '0;
            r_rd_base <= '0;
        end else begin
            if (w_fire) begin
                // Frame end overrides the line-wrap bank advance.
                if (s_last) begin
                    r_wcol  <= '0;
                    r_wbank <= '0;
                    r_lines <= '0;
                    r_state <= FILL;
                end else if (w_wrap) begin
                    r_wcol  <= '0;
                    r_wbank <= w_wbank_nxt;
                    if (!w_stream) begin
                        r_lines <= r_lines + 1'b1;
                        if (r_lines == WB'(NBANK - 2))
                            r_state <= STREAM;
                    end
                end else begin
                    r_wcol <= r_wcol + 1'b1;
                end
            end

            if (w_fire && w_stream) begin
                r_newest  <= s_data;
                r_valid   <= 1'b1;
                r_last    <= s_last;
                r_rd_base <= w_wbank_nxt;
            end else if (m_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule
